// File: rtl/io_bus_pkg.sv
// Shared types and constants for the 68k IO-window channel decoder.
package io_bus_pkg;

  typedef enum logic [2:0] {
    StArmed,
    StIdle,
    StWait,
    StAck,
    StTmo,
    StBerr
  } state_e;

  localparam logic [15:0] IO_WIN_BASE  = 16'h0040;
  localparam int unsigned APERTURE_LSB = 4;
  localparam int unsigned WAIT_W       = 4;
  localparam int unsigned TMO_W        = 8;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_addr_match.sv
// Combinational aperture matcher: page address -> {hit, lowest matching channel}.
module io_addr_match
  import io_bus_pkg::*;
#(
  parameter int unsigned           NUM_CH    = 4,
  parameter logic [NUM_CH*16-1:0]  BASE_LIST = {16'h8060, 16'h8040, 16'h8020, 16'h8000},
  localparam int unsigned          SEL_W     = sel_width(NUM_CH),
  localparam int unsigned          PAGE_W    = 16 - APERTURE_LSB
) (
  input  logic [PAGE_W-1:0] page,
  output logic              hit,
  output logic [SEL_W-1:0]  sel
);

  // Scan from the top down so the lowest matching channel is the last writer.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int n = int'(NUM_CH) - 1; n >= 0; n--) begin
      if (page == BASE_LIST[n*16+APERTURE_LSB +: PAGE_W]) begin
        hit = 1'b1;
        sel = SEL_W'(n);
      end
    end
  end

endmodule

// File: rtl/io_bus_decoder_dtack.sv
// Multi-channel IO decoder: claims a bus cycle, enables one channel, and returns a
// wait-stated DTACK, or a bus error when no channel claims the cycle in time.
module io_bus_decoder_dtack
  import io_bus_pkg::*;
#(
  parameter int unsigned               NUM_CH    = 4,
  parameter logic [NUM_CH*16-1:0]      BASE_LIST = {16'h8060, 16'h8040, 16'h8020, 16'h8000},
  parameter logic [NUM_CH*WAIT_W-1:0]  WAIT_LIST = {4'd3, 4'd2, 4'd1, 4'd0},
  parameter logic [TMO_W-1:0]          TIMEOUT   = 8'd64
) (
  input  logic              Clock,
  input  logic              Reset_H,
  input  logic [31:0]       Address,
  input  logic              IO_Select_H,
  input  logic              AS_L,
  output logic [NUM_CH-1:0] Enable_H,
  output logic              Dtack_L,
  output logic              Berr_L,
  output logic              Busy_H
);

  localparam int unsigned SEL_W = sel_width(NUM_CH);

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               hit;
  logic [SEL_W-1:0]   match_sel;
  logic               start;
  logic [NUM_CH-1:0]  en_d;
  logic               dtack_d, berr_d, busy_d;
  logic               unused_addr;

  assign start       = IO_Select_H & ~AS_L;
  assign unused_addr = ^{Address[31:16], Address[APERTURE_LSB-1:0]};

  io_addr_match #(
    .NUM_CH    (NUM_CH),
    .BASE_LIST (BASE_LIST)
  ) u_match (
    .page (Address[15:APERTURE_LSB]),
    .hit  (hit),
    .sel  (match_sel)
  );

  always_ff @(posedge Clock) begin
    if (Reset_H) begin
      state_q <= StArmed;
      cnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  // A strobe release always wins over counting: the CPU has abandoned the cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    unique case (state_q)
      StArmed: if (AS_L) state_d = StIdle;
      StIdle: begin
        if (start) begin
          if (hit) begin
            state_d = StWait;
            sel_d   = match_sel;
            cnt_d   = TMO_W'(WAIT_LIST[int'(match_sel)*WAIT_W +: WAIT_W]);
          end else begin
            state_d = StTmo;
            cnt_d   = TIMEOUT - TMO_W'(1);
          end
        end
      end
      StWait, StTmo: begin
        if (AS_L)                state_d = StIdle;
        else if (cnt_q == '0)    state_d = (state_q == StWait) ? StAck : StBerr;
        else                     cnt_d   = cnt_q - TMO_W'(1);
      end
      StAck, StBerr: if (AS_L) state_d = StIdle;
      default: state_d = StArmed;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they track state_q.
  always_comb begin
    en_d = '0;
    if (state_d == StWait || state_d == StAck) en_d[sel_d] = 1'b1;
    dtack_d = (state_d != StAck);
    berr_d  = (state_d != StBerr);
    busy_d  = (state_d != StIdle) && (state_d != StArmed);
  end

  always_ff @(posedge Clock) begin
    if (Reset_H) begin
      Enable_H <= '0;
      Dtack_L  <= 1'b1;
      Berr_L   <= 1'b1;
      Busy_H   <= 1'b0;
    end else begin
      Enable_H <= en_d;
      Dtack_L  <= dtack_d;
      Berr_L   <= berr_d;
      Busy_H   <= busy_d;
    end
  end

endmodule

// File: tb/tb_io_bus_decoder_dtack.sv
// Directed and randomized bench for io_bus_decoder_dtack against a cycle-count model.
module tb_io_bus_decoder_dtack;

  localparam int TMO = 64;

  logic        Clock;
  logic        Reset_H;
  logic [31:0] Address;
  logic        IO_Select_H;
  logic        AS_L;
  logic [3:0]  Enable_H;
  logic        Dtack_L;
  logic        Berr_L;
  logic        Busy_H;

  int compared   = 0;
  int mismatched = 0;

  int unsigned base_tab [4] = '{32'h8000, 32'h8020, 32'h8040, 32'h8060};
  int          wait_tab [4] = '{0, 1, 2, 3};

  io_bus_decoder_dtack #(
    .NUM_CH    (4),
    .BASE_LIST ({16'h8060, 16'h8040, 16'h8020, 16'h8000}),
    .WAIT_LIST ({4'd3, 4'd2, 4'd1, 4'd0}),
    .TIMEOUT   (8'd64)
  ) dut (
    .Clock       (Clock),
    .Reset_H     (Reset_H),
    .Address     (Address),
    .IO_Select_H (IO_Select_H),
    .AS_L        (AS_L),
    .Enable_H    (Enable_H),
    .Dtack_L     (Dtack_L),
    .Berr_L      (Berr_L),
    .Busy_H      (Busy_H)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] en, input logic dtack,
                            input logic berr, input logic busy);
    check({tag, " en"},    32'(Enable_H), 32'(en));
    check({tag, " dtack"}, 32'(Dtack_L),  32'(dtack));
    check({tag, " berr"},  32'(Berr_L),   32'(berr));
    check({tag, " busy"},  32'(Busy_H),   32'(busy));
  endtask

  function automatic int ch_of(input logic [31:0] addr);
    for (int i = 0; i < 4; i++) if ((addr & 32'h0000_fff0) == base_tab[i]) return i;
    return -1;
  endfunction

  // One strobe: AS_L low for 'hold' sampled edges, then one sampled high edge.
  // Cycle c (1..hold) is observed just after the c-th edge following the start.
  task automatic run_txn(input string name, input logic [31:0] addr, input logic sel,
                         input int hold);
    int  ch   = ch_of(addr);
    bit  st   = sel;
    logic [3:0] en_e;
    Address     = addr;
    IO_Select_H = sel;
    AS_L        = 1'b0;
    for (int c = 1; c <= hold; c++) begin
      tick();
      en_e = (st && ch >= 0) ? 4'(1 << ch) : 4'b0;
      check_outs($sformatf("%s c%0d", name, c), en_e,
                 !(st && ch >= 0 && c >= wait_tab[(ch < 0) ? 0 : ch] + 2),
                 !(st && ch < 0 && c >= TMO + 1), st);
      if (st) begin
        Address     = $urandom;
        IO_Select_H = 1'($urandom_range(0, 1));
      end
    end
    AS_L = 1'b1;
    tick();
    check_outs($sformatf("%s release", name), 4'b0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    logic [31:0] addr;
    int          kind, hold, gap;

    // Reset with a strobe already active: nothing may start until AS_L is seen high.
    Reset_H = 1'b1; AS_L = 1'b0; IO_Select_H = 1'b1; Address = 32'h0040_8020;
    tick();
    check_outs("reset", 4'b0, 1'b1, 1'b1, 1'b0);
    tick();
    Reset_H = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_outs($sformatf("armed %0d", i), 4'b0, 1'b1, 1'b1, 1'b0);
    end
    AS_L = 1'b1;
    tick();
    check_outs("armed exit", 4'b0, 1'b1, 1'b1, 1'b0);

    run_txn("ch0 read",  32'h0040_8000, 1'b1, 4);
    run_txn("ch3 write", 32'h0040_8060, 1'b1, 7);
    run_txn("unmapped",  32'h0040_8100, 1'b1, 70);
    run_txn("ch1 abort", 32'h0040_8020, 1'b1, 2);
    run_txn("ch2 next",  32'h0040_8040, 1'b1, 5);

    // Reset while acknowledging.
    Address = 32'h0040_8000; IO_Select_H = 1'b1; AS_L = 1'b0;
    tick();
    check_outs("rst-ack c1", 4'b0001, 1'b1, 1'b1, 1'b1);
    tick();
    check_outs("rst-ack c2", 4'b0001, 1'b0, 1'b1, 1'b1);
    Reset_H = 1'b1;
    tick();
    check_outs("rst-ack reset", 4'b0, 1'b1, 1'b1, 1'b0);
    Reset_H = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs($sformatf("rst-ack armed %0d", i), 4'b0, 1'b1, 1'b1, 1'b0);
    end
    AS_L = 1'b1;
    tick();
    check_outs("rst-ack exit", 4'b0, 1'b1, 1'b1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 4);
      if (kind < 4) begin
        addr = (32'($urandom_range(0, 16'hffff)) << 16) | base_tab[kind]
             | 32'($urandom_range(0, 15));
        hold = $urandom_range(1, 8);
      end else begin
        do addr = $urandom; while (ch_of(addr) >= 0);
        hold = ($urandom_range(0, 2) == 0) ? $urandom_range(60, 70) : $urandom_range(1, 8);
      end
      run_txn($sformatf("rnd%0d", t), addr, 1'($urandom_range(0, 7) != 0), hold);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        Address = $urandom; IO_Select_H = 1'($urandom_range(0, 1));
        tick();
        check_outs($sformatf("rnd%0d gap%0d", t, g), 4'b0, 1'b1, 1'b1, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
